// File: rtl/seq_bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and a counter-width helper.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_bin2bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = (d_i >= BCD_DIGIT_W'(5)) ? d_i + BCD_DIGIT_W'(3) : d_i;
  end

endmodule

// File: rtl/seq_bin2bcd.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blank mask enabled by SEQ_BIN2BCD_LZ_BLANK_EN.
module seq_bin2bcd
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W    = 7,
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [IN_W-1:0]       NUM,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  ERR,
  output logic [DIGITS-1:0]     BLANK
);

  localparam int unsigned SW    = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = clog2(IN_W);
  localparam logic [IN_W-1:0] MAX_V = IN_W'(MAX_VAL);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [SW-1:0]     scratch_q, scratch_d, scratch_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [SW+IN_W-1:0] shl;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scratch_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .d_o (scratch_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    done_d    = 1'b0;
    shl       = {scratch_adj, shreg_q} << 1;
    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          if (NUM > MAX_V) begin
            bcd_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            shreg_d   = NUM;
            scratch_d = '0;
            cnt_d     = CNT_W'(IN_W - 1);
            state_d   = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = shl[SW+IN_W-1:IN_W];
        shreg_d   = shl[IN_W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          bcd_d   = scratch_d;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign BUSY = (state_q == SHIFT);
  assign DONE = done_q;
  assign BCD  = bcd_q;
  assign ERR  = err_q;

`ifdef SEQ_BIN2BCD_LZ_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // lz[i]: digits i..DIGITS-1 of the next result are zero; an error result is
  // all-zero, so it yields the same {ones, 0} pattern as reset.
  logic [DIGITS-1:0] lz;
  logic [DIGITS-1:0] blank_q;

  assign lz[0] = 1'b0;
  for (genvar g = 1; g < DIGITS; g++) begin : g_lz
    if (g == DIGITS - 1) begin : g_top
      assign lz[g] = (bcd_d[BCD_DIGIT_W*g +: BCD_DIGIT_W] == '0);
    end else begin : g_mid
      assign lz[g] = (bcd_d[BCD_DIGIT_W*g +: BCD_DIGIT_W] == '0) & lz[g+1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      blank_q <= BLANK_RST;
    else if (done_d) blank_q <= lz;
  end

  assign BLANK = blank_q;
`else
  assign BLANK = '0;
`endif

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: default 7-bit/2-digit instance plus a
// 10-bit/3-digit instance for wide values and the blank mask.
module tb_seq_bin2bcd;

`ifdef SEQ_BIN2BCD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        err;
    logic [2:0]  blank;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        a_start, b_start;
  logic [6:0]  a_num;
  logic [9:0]  b_num;
  logic        a_busy, a_done, a_err, b_busy, b_done, b_err;
  logic [7:0]  a_bcd;
  logic [11:0] b_bcd;
  logic [1:0]  a_blank;
  logic [2:0]  b_blank;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   total = 0;
  int   bad   = 0;

  seq_bin2bcd #(.IN_W(7), .DIGITS(2), .MAX_VAL(59)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .START(a_start), .NUM(a_num),
    .BUSY(a_busy), .DONE(a_done), .BCD(a_bcd), .ERR(a_err), .BLANK(a_blank)
  );

  seq_bin2bcd #(.IN_W(10), .DIGITS(3), .MAX_VAL(999)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .START(b_start), .NUM(b_num),
    .BUSY(b_busy), .DONE(b_done), .BCD(b_bcd), .ERR(b_err), .BLANK(b_blank)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [2:0] bl(input logic [2:0] v);
    return LZ ? v : 3'b000;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (a_done) begin
      if (qa.size() == 0) chk("a_spurious_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_bcd", int'(a_bcd), int'(ea.bcd));
        chk("a_err", int'(a_err), int'(ea.err));
        chk("a_blank", int'(a_blank), int'(ea.blank));
      end
    end
    if (b_done) begin
      if (qb.size() == 0) chk("b_spurious_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_bcd", int'(b_bcd), int'(eb.bcd));
        chk("b_err", int'(b_err), int'(eb.err));
        chk("b_blank", int'(b_blank), int'(eb.blank));
      end
    end
  end

  // Raise START with NUM for one accepting edge; optionally record the expected result.
  task automatic req(input int d, input int n, input bit push,
                     input logic [11:0] ebcd, input logic eerr, input logic [2:0] eblank);
    exp_t e;
    e.bcd = ebcd; e.err = eerr; e.blank = eblank;
    if (d == 0) begin
      a_start = 1'b1; a_num = 7'(n);
      if (push) qa.push_back(e);
    end else begin
      b_start = 1'b1; b_num = 10'(n);
      if (push) qb.push_back(e);
    end
    @(posedge CLK); #1;
    if (d == 0) a_start = 1'b0; else b_start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int exp_lat, input int exp_busy, input string nm);
    int n, bc;
    n = 0; bc = 0;
    while (!(d == 0 ? a_done : b_done) && n < 64) begin
      if (d == 0 ? a_busy : b_busy) bc++;
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_busy"}, bc, exp_busy);
  endtask

  initial begin
    int cnt;
    RST_N = 1'b0; a_start = 1'b0; b_start = 1'b0; a_num = '0; b_num = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_a_bcd", int'(a_bcd), 0);
    chk("rst_a_err", int'(a_err), 0);
    chk("rst_a_blank", int'(a_blank), int'(bl(3'b010)));
    chk("rst_b_bcd", int'(b_bcd), 0);
    chk("rst_b_blank", int'(b_blank), int'(bl(3'b110)));
    RST_N = 1'b1;
    @(posedge CLK); #1;

    req(0, 0, 1, 12'h000, 1'b0, bl(3'b010));
    wait_done(0, 7, 7, "zero");
    @(posedge CLK); #1;
    chk("zero_done_pulse", int'(a_done), 0);
    chk("zero_bcd_hold", int'(a_bcd), 'h00);

    req(0, 59, 1, 12'h059, 1'b0, bl(3'b000));
    wait_done(0, 7, 7, "v59");
    req(0, 9, 1, 12'h009, 1'b0, bl(3'b010));
    chk("b2b_busy", int'(a_busy), 1);
    wait_done(0, 7, 7, "v09");

    req(0, 60, 1, 12'h000, 1'b1, bl(3'b010));
    wait_done(0, 0, 0, "v60");
    req(0, 127, 1, 12'h000, 1'b1, bl(3'b010));
    wait_done(0, 0, 0, "v127");
    @(posedge CLK); #1;
    chk("err_hold", int'(a_err), 1);

    req(0, 23, 1, 12'h023, 1'b0, bl(3'b000));
    @(posedge CLK); #1;
    a_start = 1'b1; a_num = 7'd12;
    @(posedge CLK); #1;
    a_start = 1'b0; a_num = 7'd0;
    wait_done(0, 5, 5, "v23");
    cnt = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (a_done) cnt++;
    end
    chk("v23_no_extra_done", cnt, 0);
    chk("v23_bcd_hold", int'(a_bcd), 'h23);

    req(0, 45, 0, 12'h000, 1'b0, 3'b000);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_bcd", int'(a_bcd), 0);
    chk("midrst_done", int'(a_done), 0);
    chk("midrst_blank", int'(a_blank), int'(bl(3'b010)));
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    req(0, 37, 1, 12'h037, 1'b0, bl(3'b000));
    wait_done(0, 7, 7, "v37");

    req(1, 999, 1, 12'h999, 1'b0, bl(3'b000));
    wait_done(1, 10, 10, "v999");
    req(1, 5, 1, 12'h005, 1'b0, bl(3'b110));
    wait_done(1, 10, 10, "v005");
    req(1, 1000, 1, 12'h000, 1'b1, bl(3'b110));
    wait_done(1, 0, 0, "v1000");

    repeat (3) @(posedge CLK);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
